nivel_sensor_cond: RTL and testbench

Upstream conditioning stage for the irrigation control FSM. It takes raw, asynchronous tank-level sensors (low/mid/high) and operator mode switches (sprinkler/drip), then synchronizes and debounces each one. It checks the debounced set for plausibility and produces the clean L, M, H, Bs, Vs and error flag E that the irrigation FSM consumes. E is driven by a persistence-filtered fault state machine, so short glitches never raise an error.

---
 rtl/nivel_pkg.sv | 35 +++
 rtl/deb_canal.sv | 65 ++++++
 rtl/nivel_sensor_cond.sv | 180 ++++++++++++++++++
 tb/tb_nivel_sensor_cond.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nivel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nivel_pkg
//  Description : Shared encodings for the level-sensor conditioning block:
//                fault-FSM state codes, fault-cause codes and a helper that
//                packs the two plausibility flags into a cause code.
//  Revision    : 1.0 - initial release
// ============================================================================
package nivel_pkg;

  // Fault FSM state encodings (2 bits)
  localparam logic [1:0] S_OK      = 2'd0;
  localparam logic [1:0] S_SUSPECT = 2'd1;
  localparam logic [1:0] S_FAULT   = 2'd2;
  localparam logic [1:0] S_RECOVER = 2'd3;

  // Fault cause codes reported on Err_code
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LVL  = 2'b01;
  localparam logic [1:0] ERR_SW   = 2'b10;
  localparam logic [1:0] ERR_BOTH = 2'b11;

  function automatic logic [1:0] err_cause(input logic lvl_bad, input logic sw_bad);
    logic [1:0] code;
    case ({sw_bad, lvl_bad})
      2'b01:   code = ERR_LVL;
      2'b10:   code = ERR_SW;
      2'b11:   code = ERR_BOTH;
      default: code = ERR_NONE;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/deb_canal.sv
`default_nettype none
// ============================================================================
//  Module      : deb_canal
//  Description : One conditioning channel: 2-flop synchronizer followed by a
//                consecutive-difference debouncer. The debounced value flips
//                on the DEB_CYCLES-th consecutive edge where the synced value
//                differs from it.
//  Ports       : Clk, Rst (async, active-high)
//                Raw_i  - raw asynchronous input
//                Deb_o  - debounced, synchronous output
//  Revision    : 1.0 - initial release
// ============================================================================
module deb_canal #(
  parameter int DEB_CYCLES = 16,
  parameter int CW         = 8
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Raw_i,
  output logic Deb_o
);
  import nivel_pkg::*;

  localparam logic [CW-1:0] c_DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] c_ONE      = CW'(1);

  logic          sync1_q;
  logic          sync2_q;
  logic          deb_q;
  logic          deb_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == c_DEB_LAST) begin
      // This edge is the DEB_CYCLES-th differing one
      deb_d = ~deb_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + c_ONE;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= Raw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Deb_o = deb_q;

endmodule
`default_nettype wire

// File: rtl/nivel_sensor_cond.sv
`default_nettype none
// ============================================================================
//  Module      : nivel_sensor_cond
//  Description : Conditions tank-level sensors (L/M/H) and mode switches
//                (Bs/Vs): synchronize + debounce each, check plausibility,
//                and drive a persistence-filtered fault flag E with cause code.
//                Build option ERR_STICKY_EN: adds Err_ack; a fault is only
//                left by acknowledging it while the inputs are plausible.
//  Ports       : Clk, Rst (async, active-high)
//                Ls_raw/Ms_raw/Hs_raw - raw level sensors
//                Bs_raw/Vs_raw        - raw sprinkler/drip switches
//                Err_ack              - fault acknowledge (ERR_STICKY_EN only)
//                L/M/H                - debounced levels
//                Bs/Vs                - debounced switches, forced 0 while E
//                E, Err_code          - fault flag and cause
//  Revision    : 1.0 - initial release
// ============================================================================
module nivel_sensor_cond #(
  parameter int DEB_CYCLES = 16,
  parameter int ERR_CYCLES = 8,
  parameter int CLR_CYCLES = 32,
  parameter int CW         = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Ls_raw,
  input  logic       Ms_raw,
  input  logic       Hs_raw,
  input  logic       Bs_raw,
  input  logic       Vs_raw,
`ifdef ERR_STICKY_EN
  input  logic       Err_ack,
`endif
  output logic       L,
  output logic       M,
  output logic       H,
  output logic       Bs,
  output logic       Vs,
  output logic       E,
  output logic [1:0] Err_code
);
  import nivel_pkg::*;

  localparam logic [CW-1:0] c_ERR_LAST = CW'(ERR_CYCLES - 1);
`ifndef ERR_STICKY_EN
  localparam logic [CW-1:0] c_CLR_LAST = CW'(CLR_CYCLES - 1);
`endif
  localparam logic [CW-1:0] c_ONE      = CW'(1);

  // Channel order: {L, M, H, Bs, Vs}
  logic [4:0] w_raw;
  logic [4:0] w_deb;

  assign w_raw = {Ls_raw, Ms_raw, Hs_raw, Bs_raw, Vs_raw};

  for (genvar gi = 0; gi < 5; gi++) begin : g_deb
    deb_canal #(
      .DEB_CYCLES (DEB_CYCLES),
      .CW         (CW)
    ) u_deb (
      .Clk   (Clk),
      .Rst   (Rst),
      .Raw_i (w_raw[gi]),
      .Deb_o (w_deb[gi])
    );
  end

  logic w_l_d, w_m_d, w_h_d, w_bs_d, w_vs_d;
  assign {w_l_d, w_m_d, w_h_d, w_bs_d, w_vs_d} = w_deb;

  logic       w_lvl_bad;
  logic       w_sw_bad;
  logic       w_bad;
  logic [1:0] w_cause;

  // Level sensors are stacked: a higher one wet implies the lower one wet
  assign w_lvl_bad = (w_m_d & ~w_l_d) | (w_h_d & ~w_m_d);
  assign w_sw_bad  = w_bs_d & w_vs_d;
  assign w_bad     = w_lvl_bad | w_sw_bad;
  assign w_cause   = err_cause(w_lvl_bad, w_sw_bad);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    err_q, err_d;
  logic          e_q, e_d;

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_OK;
      cnt_q   <= '0;
      err_q   <= ERR_NONE;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      e_q     <= e_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_OK: begin
        if (w_bad) begin
          state_d = S_SUSPECT;
          cnt_d   = c_ONE;
        end
      end
      S_SUSPECT: begin
        if (!w_bad) begin
          state_d = S_OK;
          cnt_d   = '0;
        end else if (cnt_q == c_ERR_LAST) begin
          state_d = S_FAULT;
          cnt_d   = '0;
          err_d   = w_cause;
        end else begin
          cnt_d = cnt_q + c_ONE;
        end
      end
      S_FAULT: begin
`ifdef ERR_STICKY_EN
        if (Err_ack && !w_bad) begin
          state_d = S_OK;
          err_d   = ERR_NONE;
        end else begin
          err_d = err_q | w_cause;
        end
`else
        if (!w_bad) begin
          state_d = S_RECOVER;
          cnt_d   = c_ONE;
        end else begin
          err_d = err_q | w_cause;
        end
`endif
      end
`ifndef ERR_STICKY_EN
      S_RECOVER: begin
        if (w_bad) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end else if (cnt_q == c_CLR_LAST) begin
          state_d = S_OK;
          cnt_d   = '0;
          err_d   = ERR_NONE;
        end else begin
          cnt_d = cnt_q + c_ONE;
        end
      end
`endif
      default: begin
        state_d = S_OK;
        cnt_d   = '0;
        err_d   = ERR_NONE;
      end
    endcase
  end

  // Output logic: E is decoded from the next state so it registers together
  // with the state transition.
  always_comb begin
    e_d = (state_d == S_FAULT) || (state_d == S_RECOVER);
  end

  assign L        = w_l_d;
  assign M        = w_m_d;
  assign H        = w_h_d;
  assign Bs       = w_bs_d & ~e_q;
  assign Vs       = w_vs_d & ~e_q;
  assign E        = e_q;
  assign Err_code = err_q;

endmodule
`default_nettype wire

// File: tb/tb_nivel_sensor_cond.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nivel_sensor_cond
//  Description : Self-checking bench for nivel_sensor_cond (default params).
//                Expected output words {L,M,H,Bs,Vs,E,Err_code} are queued
//                with the edge count at which they are due and compared on
//                the following falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nivel_sensor_cond;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       Ls_raw = 1'b0, Ms_raw = 1'b0, Hs_raw = 1'b0;
  logic       Bs_raw = 1'b0, Vs_raw = 1'b0;
`ifdef ERR_STICKY_EN
  logic       Err_ack = 1'b0;
`endif
  logic       L, M, H, Bs, Vs, E;
  logic [1:0] Err_code;
  logic [7:0] dut_o;

  nivel_sensor_cond #(
    .DEB_CYCLES (16),
    .ERR_CYCLES (8),
    .CLR_CYCLES (32),
    .CW         (8)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Ls_raw   (Ls_raw),
    .Ms_raw   (Ms_raw),
    .Hs_raw   (Hs_raw),
    .Bs_raw   (Bs_raw),
    .Vs_raw   (Vs_raw),
`ifdef ERR_STICKY_EN
    .Err_ack  (Err_ack),
`endif
    .L        (L),
    .M        (M),
    .H        (H),
    .Bs       (Bs),
    .Vs       (Vs),
    .E        (E),
    .Err_code (Err_code)
  );

  always #5 Clk = ~Clk;

  assign dut_o = {L, M, H, Bs, Vs, E, Err_code};

  typedef struct {
    int         due;
    logic [7:0] v;
    string      nm;
  } exp_t;

  typedef struct {
    logic [4:0] raw;   // {Ls, Ms, Hs, Bs, Vs}
    int         hold;
    logic [7:0] v;
    string      nm;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];
  int   cyc_cnt = 0;
  int   n_chk   = 0;
  int   n_pass  = 0;

  always @(posedge Clk) cyc_cnt <= cyc_cnt + 1;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got {L,M,H,Bs,Vs,E,Err}=%b expected %b (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic sched(input string nm, input int dly, input logic [7:0] v);
    exp_t e;
    e.due = cyc_cnt + dly;
    e.v   = v;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic drive(input logic [4:0] r);
    {Ls_raw, Ms_raw, Hs_raw, Bs_raw, Vs_raw} = r;
  endtask

  // Scoreboard consumer
  always @(negedge Clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc_cnt) begin
      exp_t e;
      e = sb.pop_front();
      if (e.due == cyc_cnt) cmp(e.nm, dut_o, e.v);
      else begin
        n_chk++;
        $display("FAIL %s: check missed its due edge %0d (now %0d)", e.nm, e.due, cyc_cnt);
      end
    end
  end

  initial begin
    tbl[0] = '{raw: 5'b10000, hold: 20, v: 8'b1000_0000, nm: "l_only"};
    tbl[1] = '{raw: 5'b11000, hold: 20, v: 8'b1100_0000, nm: "lm"};
    tbl[2] = '{raw: 5'b11100, hold: 20, v: 8'b1110_0000, nm: "lmh"};
    tbl[3] = '{raw: 5'b11110, hold: 20, v: 8'b1111_0000, nm: "lmh_bs"};
    tbl[4] = '{raw: 5'b11101, hold: 20, v: 8'b1110_1000, nm: "lmh_vs"};
    tbl[5] = '{raw: 5'b00000, hold: 20, v: 8'b0000_0000, nm: "all_low"};
    tbl[6] = '{raw: 5'b10000, hold: 20, v: 8'b1000_0000, nm: "l_again"};
    tbl[7] = '{raw: 5'b11100, hold: 20, v: 8'b1110_0000, nm: "lmh_again"};

    // Reset
    #2 Rst = 1'b1;
    #2 cmp("reset_async", dut_o, 8'h00);
    cyc(3);
    cmp("reset_held", dut_o, 8'h00);
    Rst = 1'b0;

    // Short pulse is filtered, then a held step appears on the 18th edge
    Ls_raw = 1'b1;
    cyc(10);
    Ls_raw = 1'b0;
    sched("glitch", 30, 8'h00);
    cyc(30);
    Ls_raw = 1'b1;
    sched("l_pre", 17, 8'h00);
    sched("l_step", 18, 8'b1000_0000);
    cyc(20);

    // Static plausible patterns
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].raw);
      sched(tbl[i].nm, tbl[i].hold, tbl[i].v);
      cyc(tbl[i].hold);
    end

    // Implausible level for 5 edges only: no error
    Ms_raw = 1'b0;
    sched("sus_mid", 22, 8'b1010_0000);
    sched("sus_end", 40, 8'b1000_0000);
    cyc(5);
    Hs_raw = 1'b0;
    cyc(35);

    // Persistent level fault: E on the 8th edge after H rises
    Hs_raw = 1'b1;
    sched("h_pre", 25, 8'b1010_0000);
    sched("lvl_fault", 26, 8'b1010_0101);
    cyc(30);
`ifdef ERR_STICKY_EN
    Err_ack = 1'b1;
    sched("ack_ignored", 1, 8'b1010_0101);
    cyc(1);
    Err_ack = 1'b0;
    cyc(2);
`endif

    // Recovery interrupted at plausible edge 20, then a full recovery
    Ms_raw = 1'b1;
    sched("rec_mid", 37, 8'b1110_0101);
    cyc(20);
    Ms_raw = 1'b0;
    sched("refault", 35, 8'b1010_0101);
    cyc(40);
    Ms_raw = 1'b1;
`ifdef ERR_STICKY_EN
    sched("sticky_hold", 50, 8'b1110_0101);
    cyc(52);
    Err_ack = 1'b1;
    sched("ack_clear", 1, 8'b1110_0000);
    cyc(1);
    Err_ack = 1'b0;
    cyc(3);
`else
    sched("rec_pre", 49, 8'b1110_0101);
    sched("rec_done", 50, 8'b1110_0000);
    cyc(55);
`endif

    // Switch fault: both selects on
    Bs_raw = 1'b1;
    Vs_raw = 1'b1;
    sched("sw_pre", 25, 8'b1111_1000);
    sched("sw_fault", 26, 8'b1110_0110);
    cyc(30);
    Bs_raw = 1'b0;
    Vs_raw = 1'b0;
`ifdef ERR_STICKY_EN
    sched("sw_sticky", 60, 8'b1110_0110);
    cyc(62);
    Err_ack = 1'b1;
    sched("sw_ack", 1, 8'b1110_0000);
    cyc(1);
    Err_ack = 1'b0;
    cyc(3);
`else
    sched("sw_rec_pre", 49, 8'b1110_0110);
    sched("sw_rec", 50, 8'b1110_0000);
    cyc(52);
`endif

    // Simultaneous level and switch fault
    Ms_raw = 1'b0;
    Bs_raw = 1'b1;
    Vs_raw = 1'b1;
    sched("both_pre", 25, 8'b1011_1000);
    sched("both_fault", 26, 8'b1010_0111);
    cyc(30);

    // Asynchronous reset in the middle of a fault
    #3 Rst = 1'b1;
    #1 cmp("async_rst", dut_o, 8'h00);
    cyc(2);
    Rst = 1'b0;
    sched("post_rst", 2, 8'h00);
    cyc(4);

    // Drain with a bound
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge Clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_chk++;
      $display("FAIL %s: never compared (due edge %0d)", e.nm, e.due);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
